// File: rtl/pass_banner_gen_if.sv
// Pixel, prompt-edit and key-entry signals of the password banner generator.
// Optional `reveal` member exists only when REVEAL_EN is defined.
interface pass_banner_gen_if;
    logic [9:0] x;
    logic [9:0] y;
    logic       blink_en;
    logic       prm_we;
    logic [3:0] prm_idx;
    logic [6:0] prm_char;
    logic       prm_len_we;
    logic [4:0] prm_len;
    logic       key_valid;
    logic [6:0] key_char;
    logic       key_bksp;
    logic       key_clr;
`ifdef REVEAL_EN
    logic       reveal;
`endif
    logic [4:0] entry_len;
    logic       entry_full;
    logic       phase;
    logic [6:0] char_addr;
    logic [4:0] char_row;
    logic [3:0] char_col;
    logic       in_text;

    modport master (
`ifdef REVEAL_EN
        output reveal,
`endif
        output x, y, blink_en, prm_we, prm_idx, prm_char, prm_len_we, prm_len,
        output key_valid, key_char, key_bksp, key_clr,
        input  entry_len, entry_full, phase, char_addr, char_row, char_col, in_text
    );

    modport slave (
`ifdef REVEAL_EN
        input  reveal,
`endif
        input  x, y, blink_en, prm_we, prm_idx, prm_char, prm_len_we, prm_len,
        input  key_valid, key_char, key_bksp, key_clr,
        output entry_len, entry_full, phase, char_addr, char_row, char_col, in_text
    );
endinterface

// File: rtl/pass_banner_gen.sv
// Blinking prompt/mask text row generator producing font-ROM character addresses per pixel.
// Define REVEAL_EN to add a reveal input that shows entered characters instead of the mask.
module pass_banner_gen #(
    parameter int unsigned MAX_CHARS    = 8,
    parameter int unsigned ORIGIN_X     = 16,
    parameter int unsigned ORIGIN_Y     = 192,
    parameter int unsigned CELL_W       = 16,
    parameter int unsigned CELL_H       = 32,
    parameter int unsigned PITCH        = 32,
    parameter int unsigned BLINK_CYCLES = 100_000_000,
    parameter logic [6:0]  MASK_CHAR    = 7'h2d
) (
    input  logic              main_clk,
    input  logic              rst,
    pass_banner_gen_if.slave  bus
);
    localparam int unsigned CNT_W   = $clog2(BLINK_CYCLES);
    localparam int unsigned SH      = $clog2(PITCH);
    localparam logic [4:0]  LEN_MAX = 5'(MAX_CHARS);
    localparam logic [4:0]  LEN_RST = (MAX_CHARS < 8) ? 5'(MAX_CHARS) : 5'd8;

    function automatic logic [6:0] rst_char(input int unsigned i);
        case (i)
            0:       return 7'h50;
            1:       return 7'h41;
            2:       return 7'h53;
            3:       return 7'h53;
            4:       return 7'h57;
            5:       return 7'h4f;
            6:       return 7'h52;
            7:       return 7'h44;
            default: return 7'h00;
        endcase
    endfunction

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic [6:0]       prompt_q [MAX_CHARS];
    logic [6:0]       prompt_d [MAX_CHARS];
    logic [4:0]       prm_len_q, prm_len_d;
    logic [4:0]       entry_len_q, entry_len_d;
    logic             entry_full_q, entry_full_d;
    logic [6:0]       char_addr_q, char_addr_d;
    logic [4:0]       char_row_q, char_row_d;
    logic [3:0]       char_col_q, char_col_d;
    logic             in_text_q, in_text_d;

`ifdef REVEAL_EN
    logic [6:0]       entry_q [MAX_CHARS];
    logic [6:0]       entry_d [MAX_CHARS];
`else
    logic             unused_key_char;
    assign unused_key_char = ^bus.key_char;
`endif

    logic [10:0] dx, dy, idx, col;
    logic [6:0]  pchar, echar;

    // Blink half-period counter and phase
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!bus.blink_en) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == CNT_W'(BLINK_CYCLES - 1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Prompt buffer and length writes
    always_comb begin
        prompt_d  = prompt_q;
        prm_len_d = prm_len_q;
        for (int unsigned i = 0; i < MAX_CHARS; i++) begin
            if (bus.prm_we && (bus.prm_idx == 4'(i))) prompt_d[i] = bus.prm_char;
        end
        if (bus.prm_len_we) prm_len_d = (bus.prm_len > LEN_MAX) ? LEN_MAX : bus.prm_len;
    end

    // Key entry: clear beats backspace beats new key
    always_comb begin
        entry_len_d = entry_len_q;
`ifdef REVEAL_EN
        entry_d = entry_q;
`endif
        if (bus.key_clr) begin
            entry_len_d = '0;
        end else if (bus.key_bksp) begin
            if (entry_len_q != 5'd0) entry_len_d = entry_len_q - 5'd1;
        end else if (bus.key_valid && (entry_len_q != LEN_MAX)) begin
`ifdef REVEAL_EN
            for (int unsigned i = 0; i < MAX_CHARS; i++) begin
                if (entry_len_q == 5'(i)) entry_d[i] = bus.key_char;
            end
`endif
            entry_len_d = entry_len_q + 5'd1;
        end
        entry_full_d = (entry_len_d == LEN_MAX);
    end

    // Pixel-to-cell decode and character selection against pre-edge state
    always_comb begin
        dx    = {1'b0, bus.x} - 11'(ORIGIN_X);
        dy    = {1'b0, bus.y} - 11'(ORIGIN_Y);
        idx   = dx >> SH;
        col   = dx & 11'(PITCH - 1);
        pchar = '0;
        echar = MASK_CHAR;
        for (int unsigned i = 0; i < MAX_CHARS; i++) begin
            if (idx == 11'(i)) pchar = prompt_q[i];
`ifdef REVEAL_EN
            if (bus.reveal && (idx == 11'(i))) echar = entry_q[i];
`endif
        end
        in_text_d = ({1'b0, bus.x} >= 11'(ORIGIN_X)) && ({1'b0, bus.y} >= 11'(ORIGIN_Y)) &&
                    (dy < 11'(CELL_H)) && (idx < 11'(MAX_CHARS)) && (col < 11'(CELL_W));
        char_addr_d = '0;
        char_row_d  = '0;
        char_col_d  = '0;
        if (in_text_d) begin
            char_row_d = 5'(dy);
            char_col_d = 4'(col);
            if (!phase_q) begin
                if (idx < 11'(prm_len_q)) char_addr_d = pchar;
            end else begin
                if (idx < 11'(entry_len_q)) char_addr_d = echar;
            end
        end
    end

    always_ff @(posedge main_clk) begin
        if (rst) begin
            cnt_q        <= '0;
            phase_q      <= 1'b0;
            prm_len_q    <= LEN_RST;
            entry_len_q  <= '0;
            entry_full_q <= 1'b0;
            char_addr_q  <= '0;
            char_row_q   <= '0;
            char_col_q   <= '0;
            in_text_q    <= 1'b0;
            for (int unsigned i = 0; i < MAX_CHARS; i++) begin
                prompt_q[i] <= rst_char(i);
`ifdef REVEAL_EN
                entry_q[i]  <= '0;
`endif
            end
        end else begin
            cnt_q        <= cnt_d;
            phase_q      <= phase_d;
            prm_len_q    <= prm_len_d;
            entry_len_q  <= entry_len_d;
            entry_full_q <= entry_full_d;
            char_addr_q  <= char_addr_d;
            char_row_q   <= char_row_d;
            char_col_q   <= char_col_d;
            in_text_q    <= in_text_d;
            prompt_q     <= prompt_d;
`ifdef REVEAL_EN
            entry_q      <= entry_d;
`endif
        end
    end

    assign bus.entry_len  = entry_len_q;
    assign bus.entry_full = entry_full_q;
    assign bus.phase      = phase_q;
    assign bus.char_addr  = char_addr_q;
    assign bus.char_row   = char_row_q;
    assign bus.char_col   = char_col_q;
    assign bus.in_text    = in_text_q;
endmodule
